// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit combinational ALU: it latches operands from a small
// register file, drives the ALU for one cycle, then writes the result back and offers it on a handshake.
module alu_issue_ctrl #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_co,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [AW-1:0] res_rd,
  output logic          carry_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic [AW-1:0] rd_lat;
  logic [DW-1:0] regs [NREG];

  // Control FSM; every output is a register so the ALU sees glitch-free operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_rd      <= '0;
      carry_flag  <= 1'b0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_sel     <= 3'b000;
      rd_lat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            alu_op1     <= regs[instr_rs1];
            alu_op2     <= regs[instr_rs2];
            alu_sel     <= instr_op;
            rd_lat      <= instr_rd;
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          res_data   <= alu_out;
          res_rd     <= rd_lat;
          carry_flag <= alu_co;
          res_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid   <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Writeback takes priority over a direct load to the same register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst_n) begin
        regs[i] <= '0;
      end else if (state == EXEC && rd_lat == AW'(i)) begin
        regs[i] <= alu_out;
      end else if (ld_en && ld_addr == AW'(i)) begin
        regs[i] <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: models the ALU and register file, and
// scoreboards every result handshake against values predicted at issue time.
module tb_alu_issue_ctrl;
  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [2:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0;
  logic [AW-1:0] instr_rs1 = '0;
  logic [AW-1:0] instr_rs2 = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] alu_op1, alu_op2, alu_out;
  logic [2:0]    alu_sel;
  logic          alu_co;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_rd;
  logic          carry_flag;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          co;
  } exp_t;

  exp_t          sb [$];
  exp_t          mon_e;
  logic [DW-1:0] m_regs [NREG];
  int            checks = 0;
  int            errors = 0;

  alu_issue_ctrl #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_co(alu_co),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .carry_flag(carry_flag)
  );

  always #5 clk = ~clk;

  // Reference ALU: add, sub, xnor, and, move, move, negate, move.
  function automatic logic [DW:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] n;
    n = ~a + DW'(1);
    case (op)
      3'b000:  alu_f = {1'b0, a} + {1'b0, b};
      3'b001:  alu_f = {1'b0, a} - {1'b0, b};
      3'b010:  alu_f = {1'b0, ~(a ^ b)};
      3'b011:  alu_f = {1'b0, a & b};
      3'b110:  alu_f = {1'b0, n};
      default: alu_f = {1'b0, a};
    endcase
  endfunction

  assign {alu_co, alu_out} = alu_f(alu_sel, alu_op1, alu_op2);

  // Scoreboard monitor: one line per completed result handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got data=%h rd=%0d, none pending", res_data, res_rd);
      end else begin
        mon_e = sb.pop_front();
        if ({res_data, res_rd, carry_flag} !== {mon_e.data, mon_e.rd, mon_e.co}) begin
          errors++;
          $display("FAIL result: got data=%h rd=%0d co=%b, need data=%h rd=%0d co=%b",
                   res_data, res_rd, carry_flag, mon_e.data, mon_e.rd, mon_e.co);
        end else begin
          $display("result rd=%0d data=%h co=%b", res_rd, res_data, carry_flag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    m_regs[a] = d;
  endtask

  // Returns #1 after the accept edge, i.e. inside EXEC.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input bit track);
    bit          acc;
    logic [DW:0] r;
    acc = 1'b0;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        r = alu_f(op, m_regs[rs1], m_regs[rs2]);
        if (track) begin
          sb.push_back(exp_t'{data: r[DW-1:0], rd: rd, co: r[DW]});
          m_regs[rd] = r[DW-1:0];
        end
        acc = 1'b1;
      end
      tick();
    end
    instr_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL issue_accept: op=%b not accepted in 20 cycles, need acceptance", op);
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && instr_ready && !res_valid) ok = 1'b1;
    end
    tick();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d ready=%b, need 0 pending and idle", name, sb.size(), instr_ready);
    end
  endtask

  task automatic check_reg(input logic [AW-1:0] a);
    issue(3'b100, a, a, a, 1'b1);
    wait_done("readback");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    checks++;
    if ({instr_ready, res_valid, res_rd, carry_flag} !== {1'b1, 1'b0, {AW{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b rd=%0d co=%b, need 1 0 0 0",
               instr_ready, res_valid, res_rd, carry_flag);
    end
    checks++;
    if ({res_data, alu_op1, alu_op2, alu_sel} !== '0) begin
      errors++;
      $display("FAIL reset_data: res=%h op1=%h op2=%h sel=%b, need all 0", res_data, alu_op1, alu_op2, alu_sel);
    end
    for (int i = 0; i < NREG; i++) check_reg(AW'(i));
  endtask

  task automatic test_add();
    do_ld(0, 8'hF0); do_ld(1, 8'h20);
    issue(3'b000, 2, 0, 1, 1'b1);
    checks++;
    if ({alu_sel, alu_op1, alu_op2, instr_ready, res_valid} !== {3'b000, 8'hF0, 8'h20, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_exec: sel=%b op1=%h op2=%h ready=%b valid=%b, need 000 F0 20 0 0",
               alu_sel, alu_op1, alu_op2, instr_ready, res_valid);
    end
    tick();
    checks++;
    if ({res_valid, res_data, res_rd, carry_flag} !== {1'b1, 8'h10, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL add_resp: valid=%b data=%h rd=%0d co=%b, need 1 10 2 1", res_valid, res_data, res_rd, carry_flag);
    end
    wait_done("add");
    check_reg(2);
  endtask

  task automatic test_xnor_neg();
    do_ld(0, 8'hAA); do_ld(1, 8'h0F);
    issue(3'b010, 3, 0, 1, 1'b1);
    wait_done("xnor");
    checks++;
    if ({res_data, carry_flag} !== {8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL xnor: data=%h co=%b, need 5A 0", res_data, carry_flag);
    end
    issue(3'b110, 3, 3, 3, 1'b1);
    wait_done("neg");
    checks++;
    if (res_data !== 8'hA6) begin
      errors++;
      $display("FAIL neg: data=%h, need A6", res_data);
    end
  endtask

  task automatic test_backpressure();
    logic [DW:0] r;
    res_ready = 1'b0;
    issue(3'b011, 0, 1, 3, 1'b1);
    tick();
    instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 2; instr_rs1 = 0; instr_rs2 = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({res_valid, res_data, instr_ready} !== {1'b1, sb[0].data, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b data=%h ready=%b, need 1 %h 0", i, res_valid, res_data, instr_ready, sb[0].data);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    checks++;
    if ({res_valid, instr_ready} !== 2'b01) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b, need 0 1", res_valid, instr_ready);
    end
    r = alu_f(3'b000, m_regs[0], m_regs[1]);
    sb.push_back(exp_t'{data: r[DW-1:0], rd: 2'd2, co: r[DW]});
    m_regs[2] = r[DW-1:0];
    tick();
    instr_valid = 1'b0;
    checks++;
    if ({instr_ready, alu_sel, alu_op1} !== {1'b0, 3'b000, m_regs[0]}) begin
      errors++;
      $display("FAIL held_accept: ready=%b sel=%b op1=%h, need 0 000 %h", instr_ready, alu_sel, alu_op1, m_regs[0]);
    end
    wait_done("held");
  endtask

  task automatic test_ld_collision();
    do_ld(0, 8'hF0); do_ld(1, 8'h20);
    issue(3'b000, 2, 0, 1, 1'b1);
    ld_en = 1'b1; ld_addr = 2; ld_data = 8'h55;
    tick();
    ld_en = 1'b0;
    wait_done("collide_same");
    check_reg(2);
    issue(3'b000, 2, 0, 1, 1'b1);
    ld_en = 1'b1; ld_addr = 1; ld_data = 8'h55;
    tick();
    ld_en = 1'b0;
    m_regs[1] = 8'h55;
    wait_done("collide_diff");
    check_reg(1);
    check_reg(2);
  endtask

  task automatic test_reset_exec();
    do_ld(3, 8'h00); do_ld(0, 8'hF0); do_ld(1, 8'h20);
    issue(3'b000, 3, 0, 1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    checks++;
    if ({instr_ready, res_valid, alu_sel, carry_flag, res_data, res_rd} !== {1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 2'd0}) begin
      errors++;
      $display("FAIL exec_reset: ready=%b valid=%b sel=%b co=%b data=%h rd=%0d, need 1 0 000 0 00 0",
               instr_ready, res_valid, alu_sel, carry_flag, res_data, res_rd);
    end
    check_reg(3);
  endtask

  task automatic test_move();
    do_ld(0, 8'hF0); do_ld(1, 8'h20);
    issue(3'b000, 2, 0, 1, 1'b1);
    wait_done("carry_set");
    checks++;
    if (carry_flag !== 1'b1) begin
      errors++;
      $display("FAIL carry_set: co=%b, need 1", carry_flag);
    end
    do_ld(0, 8'h7F);
    issue(3'b100, 1, 0, 2, 1'b1);
    wait_done("move");
    checks++;
    if ({res_data, carry_flag} !== {8'h7F, 1'b0}) begin
      errors++;
      $display("FAIL move: data=%h co=%b, need 7F 0", res_data, carry_flag);
    end
    check_reg(1);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] rd;
    for (int i = 0; i < 12; i++) begin
      rd = AW'($urandom_range(0, NREG - 1));
      issue(3'($urandom_range(0, 7)), rd, AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)), 1'b1);
      // Load a different register during EXEC; both writes must land.
      do_ld(rd + AW'(1), DW'($urandom_range(0, 255)));
    end
    wait_done("b2b");
    for (int i = 0; i < NREG; i++) check_reg(AW'(i));
  endtask

  initial begin
    test_reset();
    test_add();
    test_xnor_neg();
    test_backpressure();
    test_ld_collision();
    test_reset_exec();
    test_move();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d results pending, need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
